// File: rtl/parser_pkg.sv
// Shared types and parser framing constants for the parser input path.
package parser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int PARSER_WORD_W    = 32;
   localparam int PARSER_MAX_WORDS = 12;
   localparam int PARSER_HDR_WORDS = 2;

endpackage

// File: rtl/parser_input_arbiter_rr_picker.sv
// Round-robin picker: rotate requests by ptr, take lowest set bit, rotate back.
module rr_picker #(
   parameter int N_PORTS = 4,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_PORTS);

   logic [N_PORTS-1:0] rot;
   logic [IDX_W:0]     pos;
   logic [IDX_W:0]     enc;
   logic [IDX_W:0]     sum;

   // rot[i] is the request i positions after ptr, so rot[0] has top priority.
   always_comb begin
      rot = '0;
      pos = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         pos = (IDX_W+1)'(i) + {1'b0, ptr};
         if (pos >= N_EXT) pos = pos - N_EXT;
         rot[i] = req[pos[IDX_W-1:0]];
      end
   end

   always_comb begin
      enc   = '0;
      found = 1'b0;
      sum   = '0;
      for (int i = N_PORTS-1; i >= 0; i--) begin
         if (rot[i]) begin
            enc   = (IDX_W+1)'(i);
            found = 1'b1;
         end
      end
      sum = enc + {1'b0, ptr};
      if (sum >= N_EXT) sum = sum - N_EXT;
      idx = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the single parser receive port,
// with a word-count watchdog that forces last at the parser's packet limit.
module parser_input_arbiter
   import parser_pkg::*;
#(
   parameter int N_PORTS   = 4,
   parameter int DATA_W    = PARSER_WORD_W,
   parameter int IDX_W     = $clog2(N_PORTS),
   parameter int MAX_WORDS = PARSER_MAX_WORDS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS*DATA_W-1:0] in_data,
   input  logic [N_PORTS-1:0]        in_val,
   input  logic [N_PORTS-1:0]        in_last,
   output logic [N_PORTS-1:0]        in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_val,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic [IDX_W-1:0]          grant_idx,
   output logic                      busy,
   output logic                      pkt_done,
   output logic                      overrun,
   input  logic                      clr_err
);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic              pkt_done_q, pkt_done_d;
   logic              overrun_q, overrun_d;

   logic [IDX_W-1:0]  pick_idx;
   logic              pick_found;
   logic [DATA_W-1:0] src_data [N_PORTS];
   logic              g_val, g_last, at_limit, accept;

   for (genvar k = 0; k < N_PORTS; k++) begin : g_src
      assign src_data[k] = in_data[k*DATA_W +: DATA_W];
   end

   rr_picker #(
      .N_PORTS (N_PORTS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (in_val),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign g_val     = in_val[grant_q];
   assign g_last    = in_last[grant_q];
   assign at_limit  = (word_cnt_q == 8'(MAX_WORDS-1));
   assign busy      = (state_q == GRANT);
   assign accept    = busy && g_val && out_ready;
   assign grant_idx = grant_q;
   assign pkt_done  = pkt_done_q;
   assign overrun   = overrun_q;

   // The granted source is wired straight through; nothing is buffered here.
   always_comb begin
      // NOTE: every output gets a default before the branch so no latch is inferred.
      out_data = '0;
      out_val  = 1'b0;
      out_last = 1'b0;
      in_ready = '0;
      if (busy) begin
         out_data          = src_data[grant_q];
         out_val           = g_val;
         out_last          = g_last | at_limit;
         in_ready[grant_q] = out_ready;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      word_cnt_d = word_cnt_q;
      pkt_done_d = 1'b0;
      overrun_d  = clr_err ? 1'b0 : overrun_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               word_cnt_d = word_cnt_q + 8'd1;
               if (out_last) begin
                  state_d    = IDLE;
                  word_cnt_d = '0;
                  rr_ptr_d   = (grant_q == IDX_W'(N_PORTS-1)) ? '0 : grant_q + 1'b1;
                  pkt_done_d = 1'b1;
                  // A truncation outranks a simultaneous clear.
                  if (at_limit && !g_last) overrun_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         word_cnt_q <= '0;
         pkt_done_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         word_cnt_q <= word_cnt_d;
         pkt_done_q <= pkt_done_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: doc/parser_input_arbiter.md
Name: parser_input_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single parser receive interface (32-bit data, val/ready, last) between N upstream stream sources. A grant is held from a packet's first word through its last word, so header, sequence and payload words of different sources never interleave. A word-count watchdog truncates runaway packets at the parser's maximum packet length and flags an error.

Parameters:
N_PORTS, 4, number of upstream sources (2..16)
DATA_W, 32, word width; must match the parser input
IDX_W, $clog2(N_PORTS), grant index width
MAX_WORDS, 12, maximum beats per packet: 2 header words plus 10 payload words

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  N_PORTS*DATA_W  source data, port k occupies bits [k*DATA_W +: DATA_W]
in_val  in  N_PORTS  per-source valid
in_last  in  N_PORTS  per-source last word of packet
in_ready  out  N_PORTS  per-source ready; at most one bit high
out_data  out  DATA_W  to parser dataIn
out_val  out  1  to parser dataIn_val
out_last  out  1  to parser dataIN_last
out_ready  in  1  from parser dataIn_ready
grant_idx  out  IDX_W  currently or last granted source
busy  out  1  high while a grant is held
pkt_done  out  1  one-cycle pulse when the last beat of a packet is accepted
overrun  out  1  sticky: a packet was truncated at MAX_WORDS
clr_err  in  1  clears overrun

Behaviour:
- Reset values while reset is high, applied asynchronously:
  - state=IDLE, rr_ptr=0, grant_idx=0, word_cnt=0.
  - out_val=0, out_last=0, out_data=0, in_ready=0.
  - busy=0, pkt_done=0, overrun=0.
- Reset asserted mid-packet aborts the grant. No beat is replayed.
- States: IDLE, GRANT.
- IDLE:
  - out_val=0 and in_ready=0.
  - If any in_val is set, the picker selects the first requester at or after rr_ptr, wrapping modulo N_PORTS.
  - grant_idx is registered and the state moves to GRANT on the next edge. Arbitration latency is 1 cycle.
  - With no requesters, the block stays in IDLE and grant_idx holds its value.
- GRANT, with g = grant_idx:
  - Combinational datapath: out_data = in_data[g], out_val = in_val[g], in_ready[g] = out_ready, all other in_ready bits = 0.
  - out_last = in_last[g] OR (word_cnt == MAX_WORDS-1).
  - A beat is accepted when out_val AND out_ready. Each accepted beat increments word_cnt.
  - An accepted beat with out_last set does all of the following on the next edge:
    - state moves to IDLE, word_cnt resets to 0.
    - rr_ptr = (g+1) mod N_PORTS.
    - pkt_done pulses (registered, 1 cycle).
  - If that beat was forced, i.e. word_cnt==MAX_WORDS-1 and in_last[g]=0, overrun is set. The source's remaining words are then arbitrated later as a new packet.
  - busy=1 throughout GRANT.
  - in_val[g] low mid-packet: the grant is held indefinitely. There is no timeout.
  - out_ready low (parser committing or output pending): the beat stalls and all state holds.
- Every packet ends with one IDLE cycle, a one-bubble gap. This also applies when the same source requests again and it is the only requester.
- Fairness: with all ports requesting continuously, grant order is 0,1,2,…,N-1,0.
- word_cnt is 8 bits wide. It cannot exceed MAX_WORDS-1 because of the forced last.
- overrun: clr_err clears it. If clr_err and a new truncation occur in the same cycle, set wins.
- Requests arriving on non-granted ports are ignored until IDLE; their in_ready stays 0.

Decomposition:
- Shared package parser_pkg holds:
  - the arb_state_t enum {IDLE, GRANT};
  - PARSER_WORD_W=32;
  - PARSER_MAX_WORDS=12;
  - PARSER_HDR_WORDS=2.
- One combinational sub-module rr_picker(req[N], ptr[IDX_W] -> idx[IDX_W], found). It is a rotate, priority-encode, un-rotate picker.
- The datapath mux stays in the top level.

Test Plan:
- Single port 1 sends 4 words (last on word 4), out_ready=1.
  - Required: grant_idx=1 one cycle after in_val, 4 beats forwarded unchanged, out_last on beat 4, pkt_done one cycle later, rr_ptr=2.
- All 4 ports request simultaneously with 3-word packets.
  - Required: packets emerge in order 0,1,2,3, no interleaving, one idle cycle between packets.
- Port 2 is granted and out_ready is held low for 5 cycles after beat 2.
  - Required: beat 2 data stays on out_data and only in_ready[2] follows out_ready. Port 0 requesting meanwhile gets no ready.
- Port 3 streams 15 words without in_last.
  - Required: beat 12 carries forced out_last=1, overrun=1, then after IDLE port 3 is re-granted for the remaining 3 words.
  - Follow-up: pulse clr_err, overrun=0.
- Reset is asserted mid-packet (beat 2 of port 1).
  - Required: all outputs are 0 immediately (asynchronously), and after release port 0's request wins first because rr_ptr=0.
- clr_err is pulsed in the same cycle a truncating beat is accepted.
  - Required: overrun=1 afterwards.
